escalonador_rr: RTL and testbench



---
 rtl/escalonador_rr.sv | 156 +++++++++++++++
 tb/tb_escalonador_rr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_rr.sv
// Round-robin process scheduler and quantum timer for the single-cycle core.
// Optional dispatch counter enabled by defining SCHED_SWITCH_CNT_EN.
module escalonador_rr #(
    parameter int N_PROC  = 4,
    parameter int PID_W   = 2,
    parameter int QUANTUM = 16,
    parameter int QW      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic             halt_in,
    input  logic             wait_in,
    input  logic             set_ctx_in,
    input  logic             load_en,
    input  logic [PID_W-1:0] load_pid,
    output logic             preempt,
    output logic [1:0]       cause,
    output logic             os_mode,
    output logic [PID_W-1:0] cur_pid,
    output logic [PID_W-1:0] next_pid,
    output logic [QW-1:0]    quantum_count,
    output logic             all_done,
    output logic [15:0]      ctx_switches
);

    typedef enum logic [1:0] {
        S_OS      = 2'd0,
        S_USER    = 2'd1,
        S_PREEMPT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_QUANTUM = 2'd1;
    localparam logic [1:0] CAUSE_WAIT    = 2'd2;
    localparam logic [1:0] CAUSE_HALT    = 2'd3;

    state_t            state_q, state_d;
    logic [N_PROC-1:0] ready_q, ready_d;
    logic [PID_W-1:0]  cur_pid_q, cur_pid_d;
    logic [QW-1:0]     quantum_count_q, quantum_count_d;
    logic [1:0]        cause_q, cause_d;
    logic [PID_W-1:0]  next_pid_c;
    logic              dispatch;

    // Candidates in search order: cur+1, cur+2, ..., cur itself last.
    logic [PID_W-1:0]  cand_pid [N_PROC];
    logic [N_PROC-1:0] cand_ready;

    generate
        for (genvar gi = 0; gi < N_PROC; gi++) begin : g_cand
            assign cand_pid[gi]   = cur_pid_q + PID_W'(gi + 1);
            assign cand_ready[gi] = ready_q[cand_pid[gi]];
        end
    endgenerate

    always_comb begin
        next_pid_c = cur_pid_q;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (cand_ready[i]) begin
                next_pid_c = cand_pid[i];
            end
        end
    end

    assign dispatch = (state_q == S_OS) && set_ctx_in && (|ready_q);

    always_comb begin
        state_d         = state_q;
        cur_pid_d       = cur_pid_q;
        quantum_count_d = quantum_count_q;
        cause_d         = cause_q;
        ready_d         = ready_q;

        if (load_en) begin
            ready_d[load_pid] = 1'b1;
        end

        case (state_q)
            S_OS: begin
                cause_d = CAUSE_NONE;
                if (dispatch) begin
                    cur_pid_d       = next_pid_c;
                    quantum_count_d = '0;
                    state_d         = S_USER;
                end
            end
            S_USER: begin
                if (instr_valid) begin
                    quantum_count_d = quantum_count_q + QW'(1);
                end
                if (halt_in) begin
                    // Clearing after the load makes halt win on the same slot.
                    ready_d[cur_pid_q] = 1'b0;
                    cause_d            = CAUSE_HALT;
                    state_d            = S_PREEMPT;
                end else if (wait_in) begin
                    cause_d = CAUSE_WAIT;
                    state_d = S_PREEMPT;
                end else if (instr_valid && (quantum_count_q == QW'(QUANTUM - 1))) begin
                    cause_d = CAUSE_QUANTUM;
                    state_d = S_PREEMPT;
                end
            end
            S_PREEMPT: begin
                cause_d = CAUSE_NONE;
                state_d = S_OS;
            end
            default: begin
                cause_d = CAUSE_NONE;
                state_d = S_OS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_OS;
            ready_q         <= '0;
            cur_pid_q       <= '0;
            quantum_count_q <= '0;
            cause_q         <= CAUSE_NONE;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            cur_pid_q       <= cur_pid_d;
            quantum_count_q <= quantum_count_d;
            cause_q         <= cause_d;
        end
    end

`ifdef SCHED_SWITCH_CNT_EN
    logic [15:0] ctx_switches_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctx_switches_q <= '0;
        end else if (dispatch && (ctx_switches_q != 16'hFFFF)) begin
            ctx_switches_q <= ctx_switches_q + 16'd1;
        end
    end

    assign ctx_switches = ctx_switches_q;
`else
    assign ctx_switches = '0;
`endif

    assign preempt       = (state_q == S_PREEMPT);
    assign cause         = cause_q;
    assign os_mode       = (state_q == S_OS);
    assign cur_pid       = cur_pid_q;
    assign next_pid      = next_pid_c;
    assign quantum_count = quantum_count_q;
    assign all_done      = (state_q == S_OS) && (ready_q == '0);

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed self-checking bench for escalonador_rr (N_PROC=4, QUANTUM=16).
module tb_escalonador_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid, halt_in, wait_in, set_ctx_in, load_en;
    logic [1:0]  load_pid;
    logic        preempt;
    logic [1:0]  cause;
    logic        os_mode;
    logic [1:0]  cur_pid, next_pid;
    logic [7:0]  quantum_count;
    logic        all_done;
    logic [15:0] ctx_switches;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sw = 0;

    escalonador_rr #(.N_PROC(4), .PID_W(2), .QUANTUM(16), .QW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .halt_in      (halt_in),
        .wait_in      (wait_in),
        .set_ctx_in   (set_ctx_in),
        .load_en      (load_en),
        .load_pid     (load_pid),
        .preempt      (preempt),
        .cause        (cause),
        .os_mode      (os_mode),
        .cur_pid      (cur_pid),
        .next_pid     (next_pid),
        .quantum_count(quantum_count),
        .all_done     (all_done),
        .ctx_switches (ctx_switches)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic count_dispatch();
`ifdef SCHED_SWITCH_CNT_EN
        exp_sw++;
`endif
    endtask

    task automatic clr_inputs();
        instr_valid = 0; halt_in = 0; wait_in = 0; set_ctx_in = 0; load_en = 0; load_pid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_preempt"}, 32'(preempt), 0);
        check({tag, "_cause"},   32'(cause), 0);
        check({tag, "_os_mode"}, 32'(os_mode), 1);
        check({tag, "_all_done"},32'(all_done), 1);
        check({tag, "_cur_pid"}, 32'(cur_pid), 0);
        check({tag, "_next_pid"},32'(next_pid), 0);
        check({tag, "_qcount"},  32'(quantum_count), 0);
        check({tag, "_ctxsw"},   32'(ctx_switches), 0);
    endtask

    initial begin
        clr_inputs();
        reset = 1;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 0;

        // Load slot 0 and dispatch it.
        load_en = 1; load_pid = 0;
        tick();
        load_en = 0;
        check("load0_all_done", 32'(all_done), 0);
        check("load0_next_pid", 32'(next_pid), 0);
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("disp0_cur_pid", 32'(cur_pid), 0);
        check("disp0_os_mode", 32'(os_mode), 0);
        check("disp0_qcount", 32'(quantum_count), 0);
        check("disp0_ctxsw", 32'(ctx_switches), 32'(exp_sw));

        // Quantum expiry; slot 2 loaded during the first instruction.
        instr_valid = 1; load_en = 1; load_pid = 2;
        tick();
        load_en = 0;
        for (int i = 0; i < 14; i++) tick();
        check("q15_qcount", 32'(quantum_count), 15);
        check("q15_preempt", 32'(preempt), 0);
        tick();
        instr_valid = 0;
        check("q16_preempt", 32'(preempt), 1);
        check("q16_cause", 32'(cause), 1);
        check("q16_os_mode", 32'(os_mode), 0);
        check("q16_qcount", 32'(quantum_count), 16);
        check("q16_next_pid", 32'(next_pid), 2);
        tick();
        check("q_os_preempt", 32'(preempt), 0);
        check("q_os_cause", 32'(cause), 0);
        check("q_os_os_mode", 32'(os_mode), 1);
        check("q_os_qcount_hold", 32'(quantum_count), 16);

        // Slot 2 runs 5 instructions, then halts.
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("disp2_cur_pid", 32'(cur_pid), 2);
        check("disp2_qcount", 32'(quantum_count), 0);
        instr_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        instr_valid = 0;
        check("run5_qcount", 32'(quantum_count), 5);
        halt_in = 1;
        tick();
        halt_in = 0;
        check("halt2_preempt", 32'(preempt), 1);
        check("halt2_cause", 32'(cause), 3);
        check("halt2_next_pid", 32'(next_pid), 0);
        tick();
        check("halt2_os_mode", 32'(os_mode), 1);
        check("halt2_all_done", 32'(all_done), 0);
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("redisp0_cur_pid", 32'(cur_pid), 0);
        check("redisp0_qcount", 32'(quantum_count), 0);
        check("redisp0_ctxsw", 32'(ctx_switches), 32'(exp_sw));

        // wait+halt together: halt wins and slot 0 (last ready) is cleared.
        wait_in = 1; halt_in = 1;
        tick();
        wait_in = 0; halt_in = 0;
        check("wh_preempt", 32'(preempt), 1);
        check("wh_cause", 32'(cause), 3);
        tick();
        check("wh_all_done", 32'(all_done), 1);
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0;
        check("empty_setctx_os_mode", 32'(os_mode), 1);
        check("empty_setctx_ctxsw", 32'(ctx_switches), 32'(exp_sw));

        // Sole ready slot 1 re-dispatched after quantum expiry.
        load_en = 1; load_pid = 1;
        tick();
        load_en = 0;
        check("load1_next_pid", 32'(next_pid), 1);
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("disp1_cur_pid", 32'(cur_pid), 1);
        instr_valid = 1;
        for (int i = 0; i < 16; i++) tick();
        instr_valid = 0;
        check("q1_preempt", 32'(preempt), 1);
        check("q1_cause", 32'(cause), 1);
        check("q1_next_pid", 32'(next_pid), 1);
        tick();
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("redisp1_cur_pid", 32'(cur_pid), 1);
        check("redisp1_os_mode", 32'(os_mode), 0);
        check("redisp1_qcount", 32'(quantum_count), 0);

        // wait keeps the slot ready.
        wait_in = 1;
        tick();
        wait_in = 0;
        check("wait_cause", 32'(cause), 2);
        tick();
        check("wait_all_done", 32'(all_done), 0);
        check("wait_cause_clr", 32'(cause), 0);

        // Slot 3: load and halt on the same slot in the same cycle.
        load_en = 1; load_pid = 3;
        tick();
        load_en = 0;
        check("load3_next_pid", 32'(next_pid), 3);
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("disp3_cur_pid", 32'(cur_pid), 3);
        load_en = 1; load_pid = 3; halt_in = 1;
        tick();
        load_en = 0; halt_in = 0;
        check("lh3_cause", 32'(cause), 3);
        tick();
        check("lh3_next_pid", 32'(next_pid), 1);
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0; count_dispatch();
        check("disp1b_cur_pid", 32'(cur_pid), 1);
        halt_in = 1;
        tick();
        halt_in = 0;
        tick();
        check("lh3_all_done", 32'(all_done), 1);
        check("final_ctxsw", 32'(ctx_switches), 32'(exp_sw));

        // Reset during PREEMPT.
        load_en = 1; load_pid = 2;
        tick();
        load_en = 0;
        set_ctx_in = 1;
        tick();
        set_ctx_in = 0;
        check("disp2b_cur_pid", 32'(cur_pid), 2);
        wait_in = 1;
        tick();
        wait_in = 0;
        check("pre_rst_preempt", 32'(preempt), 1);
        reset = 1;
        tick();
        reset = 0;
        check_reset_outputs("rst_mid");
        tick();
        check("post_rst_preempt", 32'(preempt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
